// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and default latencies for the multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_start_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational arithmetic for mult/multu/div/divu; result packed as {hi, lo}.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT:  res_o = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
      MD_MULTU: res_o = {32'b0, a_i} * {32'b0, b_i};
      // Signed / and % truncate toward zero; remainder takes the dividend's sign.
      MD_DIV: begin
        if (b_i != 32'd0) res_o = {$signed(a_i) % $signed(b_i), $signed(a_i) / $signed(b_i)};
      end
      MD_DIVU: begin
        if (b_i != 32'd0) res_o = {a_i % b_i, a_i / b_i};
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer with HI/LO registers and mthi/mtlo writes.
// Optional abort of an in-flight op via `define MD_CANCEL_EN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HILOsel,
  input  logic        cancel,
  output logic        busy,
  output logic        start,
  output logic [31:0] MDout
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend_q;
  logic             pend_ok_q;
  logic             busy_q;
  logic [63:0]      core_res;
  logic             cancel_eff;

  md_core u_core (
    .op_i  (MDctrl),
    .a_i   (A),
    .b_i   (B),
    .res_o (core_res)
  );

`ifdef MD_CANCEL_EN
  assign cancel_eff = cancel;
`else
  assign cancel_eff = cancel & 1'b0;
`endif

  assign start = is_start_op(MDctrl) && (state_q == ST_IDLE);
  assign busy  = busy_q;
  assign MDout = HILOsel ? hi_q : lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cancel_eff) begin
            case (MDctrl)
              MD_MULT, MD_MULTU: begin
                state_q   <= ST_MUL;
                cnt_q     <= MUL_LOAD;
                pend_q    <= core_res;
                pend_ok_q <= 1'b1;
                busy_q    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                state_q   <= ST_DIV;
                cnt_q     <= DIV_LOAD;
                pend_q    <= core_res;
                // Divide by zero still runs full latency but commits nothing.
                pend_ok_q <= (B != 32'd0);
                busy_q    <= 1'b1;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cancel_eff) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            if (pend_ok_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, arithmetic, mthi/mtlo, reset and cancel behaviour.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  MDctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILOsel;
  logic        cancel;
  logic        busy;
  logic        start;
  logic [31:0] MDout;

  int n_cmp;
  int n_bad;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .MDctrl  (MDctrl),
    .A       (A),
    .B       (B),
    .HILOsel (HILOsel),
    .cancel  (cancel),
    .busy    (busy),
    .start   (start),
    .MDout   (MDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    HILOsel = 1'b1;
    #1 hi = MDout;
    HILOsel = 1'b0;
    #1 lo = MDout;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] hi, lo;
    read_hilo(hi, lo);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  // Issue a start op and count the busy cycles until it clears (bounded).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    int cyc;
    MDctrl = op; A = a; B = b;
    #1 check({tag, "_start"}, 32'(start), 32'd1);
    step();
    MDctrl = MD_NONE;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] a);
    MDctrl = op; A = a;
    step();
    MDctrl = MD_NONE;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int cyc;
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; MDctrl = MD_NONE; A = '0; B = '0; HILOsel = 1'b0; cancel = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check_hilo("rst", 32'h0, 32'h0);
    #4 reset = 1'b1;
    step();

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("divu0", MD_DIVU, 32'd55, 32'd0, 10);
    check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("divneg", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10);
    check_hilo("divneg", 32'h0000_0001, 32'hFFFF_FFFD);

    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10);
    check_hilo("divu", 32'h0000_0002, 32'h0000_000E);

    write_reg(MD_MTLO, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'd0);
    check_hilo("mtlo", 32'h0000_0002, 32'h1234_5678);

    write_reg(MD_MTHI, 32'hCAFE_F00D);
    check_hilo("mthi", 32'hCAFE_F00D, 32'h1234_5678);

    // mthi while busy is ignored; reads show committed values only.
    MDctrl = MD_MULT; A = 32'd3; B = 32'd4;
    step();
    MDctrl = MD_MTHI; A = 32'hDEAD_BEEF;
    check("busy_start", 32'(start), 32'd0);
    step();
    MDctrl = MD_NONE;
    check_hilo("busy_old", 32'hCAFE_F00D, 32'h1234_5678);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
    check("busy_cycles", 32'(cyc), 32'd4);
    check_hilo("busy_done", 32'h0000_0000, 32'h0000_000C);

    // Reset during busy cycle 3 of a div.
    MDctrl = MD_DIV; A = 32'd100; B = 32'd3;
    step();
    MDctrl = MD_NONE;
    step();
    step();
    check("midrst_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 check("midrst_busy", 32'(busy), 32'd0);
    check_hilo("midrst", 32'h0, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("midrst_after_busy", 32'(busy), 32'd0);
    check_hilo("midrst_after", 32'h0, 32'h0);

    // Cancel at busy cycle 4 of a mult.
    write_reg(MD_MTLO, 32'h0000_0055);
    write_reg(MD_MTHI, 32'h0000_0066);
    MDctrl = MD_MULT; A = 32'd5; B = 32'd5;
    step();
    MDctrl = MD_NONE;
    cyc = 1;
    step(); step(); step();
    cyc = 4;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
`ifdef MD_CANCEL_EN
    check("cancel_busy", 32'(busy), 32'd0);
    check_hilo("cancel", 32'h0000_0066, 32'h0000_0055);
    for (int i = 0; i < 3; i++) step();
    check_hilo("cancel_after", 32'h0000_0066, 32'h0000_0055);
    cancel = 1'b1; MDctrl = MD_MTLO; A = 32'h0000_0099;
    step();
    cancel = 1'b0; MDctrl = MD_NONE;
    check_hilo("cancel_idle", 32'h0000_0066, 32'h0000_0055);
`else
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
    check("nocancel_cycles", 32'(cyc), 32'd5);
    check_hilo("nocancel", 32'h0000_0000, 32'h0000_0019);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
